// File: rtl/motor_ramp_ctrl.sv
// Motion sequencer for the PWM motor driver. It produces a soft-start duty ramp, a hold phase,
// a soft-stop ramp and a dead time before each reversal, and aborts at once on the travel limit.
module motor_ramp_ctrl #(
  parameter int DUTY_W   = 8,
  parameter int DUTY_MAX = 200,
  parameter int STEP_DIV = 5000,
  parameter int DEAD_CYC = 50000
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              dir_req,
  input  logic              limit_l,
  input  logic              limit_r,
  output logic              enable,
  output logic              direct,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done,
  output logic              lim_hit
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  localparam logic [PW-1:0]     STEP_LAST = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0]     DEAD_LAST = DW'(DEAD_CYC - 1);
  localparam logic [DUTY_W-1:0] DUTY_TOP  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DUTY_ONE  = DUTY_W'(1);

  typedef enum logic [2:0] {IDLE, DEAD, RAMP_UP, RUN, RAMP_DOWN} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [DW-1:0] dead_cnt;
  logic          travel_lim;
  logic          req_lim;

  // Motion limit follows the latched direction. The start check uses the requested direction.
  assign travel_lim = direct  ? limit_r : limit_l;
  assign req_lim    = dir_req ? limit_r : limit_l;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      dead_cnt <= '0;
      enable   <= 1'b0;
      direct   <= 1'b0;
      duty     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      lim_hit  <= 1'b0;
    end else begin
      // NOTE: the pulses default low on every edge. A later non-blocking assignment in the same
      // block overrides this default, so each pulse lasts exactly one cycle without extra logic.
      done    <= 1'b0;
      lim_hit <= 1'b0;
      if (state != IDLE && travel_lim) begin
        state   <= IDLE;
        enable  <= 1'b0;
        duty    <= '0;
        busy    <= 1'b0;
        lim_hit <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            enable <= 1'b0;
            duty   <= '0;
            if (start && !stop && !req_lim) begin
              busy <= 1'b1;
              if (dir_req != direct) begin
                direct   <= dir_req;
                dead_cnt <= '0;
                state    <= DEAD;
              end else begin
                presc  <= '0;
                enable <= 1'b1;
                state  <= RAMP_UP;
              end
            end
          end
          DEAD: begin
            if (dead_cnt == DEAD_LAST) begin
              presc  <= '0;
              enable <= 1'b1;
              state  <= RAMP_UP;
            end else begin
              dead_cnt <= dead_cnt + DW'(1);
            end
          end
          RAMP_UP: begin
            if (stop) begin
              presc <= '0;
              state <= RAMP_DOWN;
            end else if (presc == STEP_LAST) begin
              presc <= '0;
              duty  <= duty + DUTY_ONE;
              if (duty == DUTY_TOP - DUTY_ONE) state <= RUN;
            end else begin
              presc <= presc + PW'(1);
            end
          end
          RUN: begin
            duty <= DUTY_TOP;
            if (stop) begin
              presc <= '0;
              state <= RAMP_DOWN;
            end
          end
          RAMP_DOWN: begin
            // Entering with duty already 0 (an early stop) completes on the very next edge.
            if (duty == '0) begin
              state  <= IDLE;
              enable <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else if (presc == STEP_LAST) begin
              presc <= '0;
              duty  <= duty - DUTY_ONE;
              if (duty == DUTY_ONE) begin
                state  <= IDLE;
                enable <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          default: begin
            state  <= IDLE;
            enable <= 1'b0;
            duty   <= '0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with DUTY_MAX=4, STEP_DIV=3 and DEAD_CYC=5.
// It drives a table of per-cycle vectors and adds hand sequences for the asynchronous reset cases.
module tb_motor_ramp_ctrl;

  logic       sclk = 1'b0;
  logic       s_rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, dir_req = 1'b0, limit_l = 1'b0, limit_r = 1'b0;
  logic       enable, direct, busy, done, lim_hit;
  logic [7:0] duty;

  int n_checks = 0;
  int n_errors = 0;

  motor_ramp_ctrl #(.DUTY_W(8), .DUTY_MAX(4), .STEP_DIV(3), .DEAD_CYC(5)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .start(start), .stop(stop), .dir_req(dir_req),
    .limit_l(limit_l), .limit_r(limit_r), .enable(enable), .direct(direct),
    .duty(duty), .busy(busy), .done(done), .lim_hit(lim_hit)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    bit    st, sp, dr, ll, lr;
    int    reps;
    bit    en, di;
    int    du;
    bit    bu, dn, lh;
    string name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit st, bit sp, bit dr, bit ll, bit lr, int reps,
                              bit en, bit di, int du, bit bu, bit dn, bit lh, string name);
    vec_t v;
    v.st = st; v.sp = sp; v.dr = dr; v.ll = ll; v.lr = lr; v.reps = reps;
    v.en = en; v.di = di; v.du = du; v.bu = bu; v.dn = dn; v.lh = lh; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input bit en, input bit di, input int du,
                            input bit bu, input bit dn, input bit lh);
    check({name, ".enable"},  32'(enable),  32'(en));
    check({name, ".direct"},  32'(direct),  32'(di));
    check({name, ".duty"},    32'(duty),    du);
    check({name, ".busy"},    32'(busy),    32'(bu));
    check({name, ".done"},    32'(done),    32'(dn));
    check({name, ".lim_hit"}, 32'(lim_hit), 32'(lh));
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  initial begin
    // Scenarios 1 and 2: ramp up with direct=0, start ignored in RUN, then a soft stop.
    vecs.push_back(mk(1,0,0,0,0, 3, 1,0,0,1,0,0, "s1_up0"));
    vecs.push_back(mk(0,0,0,0,0, 3, 1,0,1,1,0,0, "s1_up1"));
    vecs.push_back(mk(0,0,0,0,0, 3, 1,0,2,1,0,0, "s1_up2"));
    vecs.push_back(mk(0,0,0,0,0, 3, 1,0,3,1,0,0, "s1_up3"));
    vecs.push_back(mk(0,0,0,0,0, 1, 1,0,4,1,0,0, "s1_top"));
    vecs.push_back(mk(0,0,0,0,0, 2, 1,0,4,1,0,0, "s1_run"));
    vecs.push_back(mk(1,0,1,0,0, 1, 1,0,4,1,0,0, "s1_start_ign"));
    vecs.push_back(mk(0,1,0,0,0, 3, 1,0,4,1,0,0, "s2_dn4"));
    vecs.push_back(mk(0,0,0,0,0, 3, 1,0,3,1,0,0, "s2_dn3"));
    vecs.push_back(mk(0,0,0,0,0, 3, 1,0,2,1,0,0, "s2_dn2"));
    vecs.push_back(mk(0,0,0,0,0, 3, 1,0,1,1,0,0, "s2_dn1"));
    vecs.push_back(mk(0,0,0,0,0, 1, 0,0,0,0,1,0, "s2_done"));
    vecs.push_back(mk(0,0,0,0,0, 2, 0,0,0,0,0,0, "s2_idle"));
    // Scenario 3: a reversal inserts the dead time, then the ramp proceeds.
    vecs.push_back(mk(1,0,1,0,0, 5, 0,1,0,1,0,0, "s3_dead"));
    vecs.push_back(mk(0,0,1,0,0, 3, 1,1,0,1,0,0, "s3_up0"));
    vecs.push_back(mk(0,0,1,0,0, 3, 1,1,1,1,0,0, "s3_up1"));
    vecs.push_back(mk(0,0,1,0,0, 3, 1,1,2,1,0,0, "s3_up2"));
    vecs.push_back(mk(0,0,1,0,0, 3, 1,1,3,1,0,0, "s3_up3"));
    vecs.push_back(mk(0,0,1,0,0, 3, 1,1,4,1,0,0, "s3_run"));
    // Scenario 4: the opposite limit is ignored. Travel limit with stop in the same cycle aborts.
    vecs.push_back(mk(0,0,1,1,0, 2, 1,1,4,1,0,0, "s4_opp_lim"));
    vecs.push_back(mk(0,1,1,0,1, 1, 0,1,0,0,0,1, "s4_abort"));
    vecs.push_back(mk(0,0,1,0,0, 2, 0,1,0,0,0,0, "s4_idle"));
    // Scenario 5: start into an asserted limit, start and stop together, skipped dead time, early stop.
    vecs.push_back(mk(1,0,1,0,1, 2, 0,1,0,0,0,0, "s5_lim_ign"));
    vecs.push_back(mk(1,1,0,0,0, 2, 0,1,0,0,0,0, "s5_both"));
    vecs.push_back(mk(1,0,1,0,0, 1, 1,1,0,1,0,0, "s5_nodead"));
    vecs.push_back(mk(0,1,1,0,0, 1, 1,1,0,1,0,0, "s5_early_stop"));
    vecs.push_back(mk(0,0,1,0,0, 1, 0,1,0,0,1,0, "s5_early_done"));
    vecs.push_back(mk(0,0,1,0,0, 1, 0,1,0,0,0,0, "s5_idle"));
    // Limit abort during the dead time.
    vecs.push_back(mk(1,0,0,0,0, 2, 0,0,0,1,0,0, "dead_enter"));
    vecs.push_back(mk(0,0,0,1,0, 1, 0,0,0,0,0,1, "dead_abort"));
    vecs.push_back(mk(0,0,0,0,0, 1, 0,0,0,0,0,0, "dead_idle"));

    #12;
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    @(negedge sclk);
    s_rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        start   = (r == 0) ? vecs[i].st : 1'b0;
        stop    = (r == 0) ? vecs[i].sp : 1'b0;
        dir_req = vecs[i].dr;
        limit_l = vecs[i].ll;
        limit_r = vecs[i].lr;
        tick();
        check_outs($sformatf("%s[%0d]", vecs[i].name, r),
                   vecs[i].en, vecs[i].di, vecs[i].du, vecs[i].bu, vecs[i].dn, vecs[i].lh);
      end
    end
    start = 1'b0; stop = 1'b0; limit_l = 1'b0; limit_r = 1'b0; dir_req = 1'b0;

    // Scenario 6: assert reset mid ramp-up at duty=2. The outputs must clear without a clock edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check_outs("s6_pre", 1, 0, 2, 1, 0, 0);
    #2;
    s_rst_n = 1'b0;
    #1;
    check_outs("s6_async", 0, 0, 0, 0, 0, 0);
    tick();
    check_outs("s6_held", 0, 0, 0, 0, 0, 0);
    #2;
    s_rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("s6_restart", 1, 0, 0, 1, 0, 0);
    tick();
    tick();
    check_outs("s6_step0", 1, 0, 0, 1, 0, 0);
    tick();
    check_outs("s6_step1", 1, 0, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
